fpu_seq: RTL and testbench

Issue/sequencing controller between the Ibex ID/EX stage and the combinational bfloat16 FPU datapath. It accepts one FP operation at a time over a valid/ready handshake, registers the operands, and drives the FPU instance. Fused multiply-add variants execute as two passes through the FPU: a multiply pass, then an add/sub pass. The result is held in a register until it is consumed over a second valid/ready handshake.

---
 rtl/fpu_seq_pkg.sv | 9 +
 rtl/fpu_seq.sv | 90 +++++++++
 tb/tb_fpu_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared FPU operator, sequencer state and fused-variant encodings.
package fpu_seq_pkg;
  typedef enum logic [3:0] {
    FP_ALU_ADD, FP_ALU_SUB, FP_ALU_MUL, FP_ALU_DIV, FP_ALU_SQRT, FP_ALU_MIN,
    FP_ALU_MAX, FP_ALU_CMP, FP_ALU_CLASS, FP_ALU_CVT, FP_ALU_MADD
  } fp_alu_op_e;
  typedef enum logic [2:0] {IDLE, EXEC, MUL, ADD, DONE} fpu_seq_state_e;
  typedef enum logic [1:0] {MADD = 2'b00, MSUB = 2'b01, NMSUB = 2'b10, NMADD = 2'b11} madd_op_e;
endpackage

// File: rtl/fpu_seq.sv
// fpu_seq: issue/sequencing controller for the combinational bfloat16 FPU; fused ops run as mul then add/sub.
module fpu_seq
  import fpu_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fp_alu_op_e  op_i,
  input  logic [1:0]  madd_op_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_c_i,
  input  logic        flush_i,
  output fp_alu_op_e  fpu_operator_o,
  output logic [31:0] fpu_operand_a_o,
  output logic [31:0] fpu_operand_b_o,
  output logic [1:0]  fpu_mode_o,
  input  logic [31:0] fpu_result_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);
  fpu_seq_state_e r_state, w_next;
  fp_alu_op_e     r_op;
  madd_op_e       r_madd;
  logic [31:0]    r_a, r_b, r_c, r_result;
  logic [15:0]    r_p;
  logic [1:0]     r_mode;
  logic           w_accept, w_sub, w_neg;
  assign w_sub       = r_madd inside {MSUB, NMADD};
  assign w_neg       = r_madd inside {NMSUB, NMADD};
  assign fpu_mode_o  = r_mode;
  assign result_o    = r_result;
  assign res_valid_o = r_state == DONE;
  assign busy_o      = r_state != IDLE;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  always_comb begin
    req_ready_o     = !flush_i && (r_state == IDLE || (r_state == DONE && res_ready_i));
    w_accept        = req_valid_i && req_ready_o;
    w_next          = r_state;
    fpu_operator_o  = r_op;
    fpu_operand_a_o = r_a;
    fpu_operand_b_o = r_b;
    case (r_state)
      IDLE, DONE: w_next = w_accept ? (op_i == FP_ALU_MADD ? MUL : EXEC)
                         : (r_state == DONE && !res_ready_i) ? DONE : IDLE;
      EXEC: w_next = DONE;
      MUL: begin
        w_next         = ADD;
        fpu_operator_o = FP_ALU_MUL;
      end
      ADD: begin
        w_next          = DONE;
        fpu_operator_o  = w_sub ? FP_ALU_SUB : FP_ALU_ADD;
        fpu_operand_a_o = {r_p, 16'd0};
        fpu_operand_b_o = r_c;
      end
      default: w_next = IDLE;
    endcase
    if (flush_i) w_next = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_op     <= FP_ALU_ADD;
      r_madd   <= MADD;
      r_mode   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_p      <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= op_i;
        r_madd <= madd_op_e'(madd_op_i);
        r_mode <= mode_i;
        r_a    <= operand_a_i;
        r_b    <= operand_b_i;
        r_c    <= operand_c_i;
      end
      // flush discards the pass in flight, so nothing is captured that cycle
      if (!flush_i && (r_state == EXEC || r_state == ADD)) r_result <= fpu_result_i;
      if (!flush_i && r_state == MUL) r_p <= fpu_result_i[31:16] ^ {w_neg, 15'd0};
    end
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: table-driven and directed checks of fpu_seq against a real-arithmetic bfloat16 FPU model.
module tb_fpu_seq;
  import fpu_seq_pkg::*;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, flush = 0, res_valid, res_ready = 1, busy;
  fp_alu_op_e op = FP_ALU_ADD, fpu_op;
  logic [1:0] madd = 0, mode = 0, fpu_mode;
  logic [31:0] a = 0, b = 0, c = 0, fpu_a, fpu_b, fpu_res, result;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fpu_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .madd_op_i(madd), .mode_i(mode), .operand_a_i(a), .operand_b_i(b),
    .operand_c_i(c), .flush_i(flush), .fpu_operator_o(fpu_op), .fpu_operand_a_o(fpu_a),
    .fpu_operand_b_o(fpu_b), .fpu_mode_o(fpu_mode), .fpu_result_i(fpu_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .result_o(result), .busy_o(busy)
  );

  function automatic real bf2r(input logic [15:0] x);
    logic [10:0] e;
    e = 11'(x[14:7]) + 11'd896;
    return x[14:0] == 15'd0 ? 0.0 : $bitstoreal({x[15], e, x[6:0], 45'd0});
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return d[62:0] == 63'd0 ? 16'd0 : {d[63], e[7:0], d[51:45]};
  endfunction

  always_comb begin
    case (fpu_op)
      FP_ALU_ADD:   fpu_res = {r2bf(bf2r(fpu_a[31:16]) + bf2r(fpu_b[31:16])), 16'd0};
      FP_ALU_SUB:   fpu_res = {r2bf(bf2r(fpu_a[31:16]) - bf2r(fpu_b[31:16])), 16'd0};
      FP_ALU_MUL:   fpu_res = {r2bf(bf2r(fpu_a[31:16]) * bf2r(fpu_b[31:16])), 16'd0};
      FP_ALU_CLASS: fpu_res = {22'd0, fpu_a[31] ? 10'h002 : 10'h040};
      default:      fpu_res = fpu_a ^ fpu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    fp_alu_op_e op; logic [1:0] madd; logic [1:0] mode;
    logic [31:0] a, b, c, res, a2; fp_alu_op_e op2; int lat;
  } vec_t;
  vec_t vecs[8];

  task automatic issue(input fp_alu_op_e o, input logic [1:0] m, input logic [1:0] md,
                       input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc);
    req_valid = 1; op = o; madd = m; mode = md; a = xa; b = xb; c = xc;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    issue(v.op, v.madd, v.mode, v.a, v.b, v.c);
    #1 chk("req_ready_idle", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    if (v.op == FP_ALU_MADD) chk("mul_pass_op", 32'(fpu_op), 32'(FP_ALU_MUL));
    else chk("exec_op", 32'(fpu_op), 32'(v.op));
    chk("mode_out", 32'(fpu_mode), 32'(v.mode));
    chk("busy_exec", 32'(busy), 1);
    while (!res_valid && lat < 8) begin
      if (v.op == FP_ALU_MADD && lat == 2) begin
        chk("add_pass_op", 32'(fpu_op), 32'(v.op2));
        chk("add_pass_a", fpu_a, v.a2);
        chk("add_pass_b", fpu_b, v.c);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("result", result, v.res);
    @(negedge clk);
    chk("back_to_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] held;
    logic seen;
    int lat;
    vecs[0] = '{FP_ALU_ADD,  2'b00, 2'b00, 32'h3F800000, 32'h40000000, 32'h0,        32'h40400000, 32'h0,        FP_ALU_ADD, 2};
    vecs[1] = '{FP_ALU_MADD, 2'b00, 2'b01, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 32'h40C00000, FP_ALU_ADD, 3};
    vecs[2] = '{FP_ALU_MADD, 2'b11, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0E00000, 32'hC0C00000, FP_ALU_SUB, 3};
    vecs[3] = '{FP_ALU_MADD, 2'b01, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40A00000, 32'h40C00000, FP_ALU_SUB, 3};
    vecs[4] = '{FP_ALU_MADD, 2'b10, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0A00000, 32'hC0C00000, FP_ALU_ADD, 3};
    vecs[5] = '{FP_ALU_MUL,  2'b00, 2'b10, 32'h40000000, 32'h40400000, 32'h0,        32'h40C00000, 32'h0,        FP_ALU_ADD, 2};
    vecs[6] = '{FP_ALU_SUB,  2'b00, 2'b11, 32'h3F800000, 32'h40000000, 32'h0,        32'hBF800000, 32'h0,        FP_ALU_ADD, 2};
    vecs[7] = '{FP_ALU_CLASS,2'b00, 2'b01, 32'hBF800000, 32'h0,        32'h0,        32'h00000002, 32'h0,        FP_ALU_ADD, 2};

    #12;
    chk("rst_result", result, 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_operator", 32'(fpu_op), 32'(FP_ALU_ADD));
    chk("rst_mode", 32'(fpu_mode), 0);
    chk("rst_operand_a", fpu_a, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // result held while the consumer stalls, then back-to-back accept on release
    @(negedge clk);
    res_ready = 0;
    issue(FP_ALU_ADD, 2'b00, 2'b00, 32'h3F800000, 32'h40000000, 0);
    @(negedge clk);
    issue(FP_ALU_MUL, 2'b00, 2'b10, 32'h40000000, 32'h40400000, 0);
    @(negedge clk);
    chk("hold_valid", 32'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req_ready", 32'(req_ready), 0);
      chk("hold_result", result, 32'h40400000);
      @(negedge clk);
    end
    res_ready = 1;
    #1 chk("release_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    chk("b2b_valid_low", 32'(res_valid), 0);
    chk("b2b_exec_op", 32'(fpu_op), 32'(FP_ALU_MUL));
    @(negedge clk);
    chk("b2b_valid", 32'(res_valid), 1);
    chk("b2b_result", result, 32'h40C00000);
    @(negedge clk);

    // flush during the multiply pass
    held = result;
    issue(FP_ALU_MADD, 2'b00, 2'b00, 32'h40000000, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    req_valid = 0;
    chk("flush_in_mul", 32'(fpu_op), 32'(FP_ALU_MUL));
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_idle", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen |= res_valid;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(seen), 0);
    chk("flush_result_kept", result, held);
    issue(FP_ALU_ADD, 2'b00, 2'b00, 32'h3F800000, 32'h3F800000, 0);
    flush = 1;
    #1 chk("flush_blocks_ready", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = 0;
    flush = 0;
    chk("flush_no_accept", 32'(busy), 0);

    // asynchronous reset in the add pass
    issue(FP_ALU_MADD, 2'b11, 2'b10, 32'h40000000, 32'h40400000, 32'h3F800000);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("pre_rst_add_a", fpu_a, 32'hC0C00000);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(res_valid), 0);
    chk("arst_result", result, 0);
    chk("arst_operator", 32'(fpu_op), 32'(FP_ALU_ADD));
    chk("arst_operand_a", fpu_a, 0);
    chk("arst_operand_b", fpu_b, 0);
    chk("arst_mode", 32'(fpu_mode), 0);
    @(negedge clk);
    rst_n = 1;
    issue(FP_ALU_CLASS, 2'b00, 2'b01, 32'h3F800000, 0, 0);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("class_latency", 32'(lat), 2);
    chk("class_result", result, 32'h00000040);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
